// File: rtl/keccak_pkg.sv
// Keccak sponge constants, sizes and absorb FSM encoding.
// Shared by absorb_stream and absorb_lane_xor.
package keccak_pkg;

    localparam int RATE_WIDTH  = 11;
    localparam int STATE_WIDTH = 1600;
    localparam int LANE_WIDTH  = 64;
    localparam int ROW_COUNT   = 5;
    localparam int COL_COUNT   = 5;
    localparam int STATE_BYTES = STATE_WIDTH / 8;
    localparam int LANE_BYTES  = LANE_WIDTH / 8;

    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_LAST     = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PERM_WAIT,
        CARRY,
        PAD,
        DONE
    } absorb_fsm_e;

    function automatic logic [7:0] min_u8(
        input logic [7:0] a,
        input logic [7:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/absorb_lane_xor.sv
// Combinational XOR of the low nbytes of a beat into the
// sponge state at a byte offset (lane (x,y) at 5y+x).
module absorb_lane_xor
    import keccak_pkg::*;
#(
    parameter int DWIDTH = 256
) (
    input  logic [STATE_WIDTH-1:0] state_in,
    input  logic [DWIDTH-1:0]      data,
    input  logic [7:0]             nbytes,
    input  logic [7:0]             offset,
    output logic [STATE_WIDTH-1:0] state_out
);

    logic [DWIDTH-1:0]      masked;
    logic [STATE_WIDTH-1:0] placed;

    always_comb begin
        masked = '0;
        for (int i = 0; i < DWIDTH / 8; i++) begin
            if (8'(i) < nbytes) begin
                masked[i*8 +: 8] = data[i*8 +: 8];
            end
        end
        placed = {{(STATE_WIDTH - DWIDTH){1'b0}}, masked}
                 << {offset, 3'b000};
        state_out = state_in ^ placed;
    end

endmodule

// File: rtl/absorb_stream.sv
// Keccak absorb front-end: streams beats into the rate, hands
// full blocks to an external permutation. ABSORB_PAD_EN adds padding.
module absorb_stream
    import keccak_pkg::*;
#(
    parameter int DWIDTH = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [RATE_WIDTH-1:0]  rate_i,
    input  logic [7:0]             suffix_i,
    input  logic                   t_valid_i,
    output logic                   t_ready_o,
    input  logic [DWIDTH-1:0]      t_data_i,
    input  logic [DWIDTH/8-1:0]    t_keep_i,
    input  logic                   t_last_i,
    input  logic [STATE_WIDTH-1:0] state_i,
    output logic [STATE_WIDTH-1:0] state_o,
    output logic                   perm_req_o,
    input  logic                   perm_done_i,
    output logic                   absorb_done_o
);

    localparam int BEAT_BYTES = DWIDTH / 8;
    localparam int CARRY_W    = DWIDTH - 8;

    absorb_fsm_e st;

    logic [7:0]         rate_bytes;
    logic [7:0]         ctr;
    logic [7:0]         carry_cnt;
    logic [CARRY_W-1:0] carry_q;
    logic               last_q;
    logic               perm_req_q;
    logic               done_q;

    logic [7:0] keep_cnt;
    logic [7:0] room;
    logic [7:0] fit;
    logic [7:0] excess;
    logic [7:0] fill;
    logic       beat_fire;

    logic [DWIDTH-1:0]      xor_data;
    logic [7:0]             xor_nbytes;
    logic [7:0]             xor_offset;
    logic [STATE_WIDTH-1:0] mixed_state;
    logic [STATE_WIDTH-1:0] merged_state;

`ifdef ABSORB_PAD_EN
    logic [7:0] suffix_q;
    logic       padded_q;
`else
    logic unused_suffix;
    assign unused_suffix = ^suffix_i;
`endif

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            keep_cnt = keep_cnt + 8'(t_keep_i[i]);
        end
        room   = rate_bytes - ctr;
        fit    = min_u8(keep_cnt, room);
        excess = keep_cnt - fit;
        fill   = ctr + fit;
    end

    assign t_ready_o = (st == ABSORB)
                     && (carry_cnt == '0)
                     && !last_q;
    assign beat_fire     = t_valid_i && t_ready_o;
    assign perm_req_o    = perm_req_q;
    assign absorb_done_o = done_q;

    // One shared XOR path: beat data, carried bytes or suffix.
    always_comb begin
        xor_data   = '0;
        xor_nbytes = '0;
        xor_offset = ctr;
        unique case (1'b1)
            (st == ABSORB): begin
                xor_data   = t_data_i;
                xor_nbytes = fit;
            end
            (st == CARRY): begin
                xor_data   = {8'h00, carry_q};
                xor_nbytes = carry_cnt;
                xor_offset = '0;
            end
`ifdef ABSORB_PAD_EN
            (st == PAD): begin
                xor_data   = DWIDTH'(suffix_q);
                xor_nbytes = 8'd1;
            end
`endif
            default: ;
        endcase
    end

    absorb_lane_xor #(
        .DWIDTH (DWIDTH)
    ) u_xor (
        .state_in  (state_o),
        .data      (xor_data),
        .nbytes    (xor_nbytes),
        .offset    (xor_offset),
        .state_out (mixed_state)
    );

`ifdef ABSORB_PAD_EN
    // Closing pad bit chains after the suffix so both may share a byte.
    absorb_lane_xor #(
        .DWIDTH (8)
    ) u_pad_end (
        .state_in  (mixed_state),
        .data      (PAD_LAST),
        .nbytes    ({7'd0, st == PAD}),
        .offset    (rate_bytes - 8'd1),
        .state_out (merged_state)
    );
`else
    assign merged_state = mixed_state;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st         <= IDLE;
            state_o    <= '0;
            rate_bytes <= '0;
            ctr        <= '0;
            carry_q    <= '0;
            carry_cnt  <= '0;
            last_q     <= 1'b0;
            perm_req_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef ABSORB_PAD_EN
            suffix_q   <= '0;
            padded_q   <= 1'b0;
`endif
        end else if (start_i) begin
            st         <= ABSORB;
            state_o    <= '0;
            rate_bytes <= 8'(rate_i >> 3);
            ctr        <= '0;
            carry_q    <= '0;
            carry_cnt  <= '0;
            last_q     <= 1'b0;
            perm_req_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef ABSORB_PAD_EN
            suffix_q   <= suffix_i;
            padded_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (st)
                IDLE: ;
                ABSORB: begin
                    if (beat_fire) begin
                        state_o <= merged_state;
                        ctr     <= fill;
                        if (fill == rate_bytes) begin
                            carry_q    <= CARRY_W'(t_data_i >> {fit, 3'b000});
                            carry_cnt  <= excess;
                            last_q     <= t_last_i;
                            perm_req_q <= 1'b1;
                            st         <= PERM_WAIT;
                        end else if (t_last_i) begin
                            last_q <= 1'b1;
`ifdef ABSORB_PAD_EN
                            st     <= PAD;
`else
                            perm_req_q <= 1'b1;
                            st         <= PERM_WAIT;
`endif
                        end
                    end
                end
                PERM_WAIT: begin
                    if (perm_done_i) begin
                        state_o    <= state_i;
                        ctr        <= '0;
                        perm_req_q <= 1'b0;
                        if (carry_cnt != '0) begin
                            st <= CARRY;
`ifdef ABSORB_PAD_EN
                        end else if (padded_q) begin
                            st     <= DONE;
                            done_q <= 1'b1;
                        end else if (last_q) begin
                            st <= PAD;
`else
                        end else if (last_q) begin
                            st     <= DONE;
                            done_q <= 1'b1;
`endif
                        end else begin
                            st <= ABSORB;
                        end
                    end
                end
                CARRY: begin
                    state_o   <= merged_state;
                    ctr       <= carry_cnt;
                    carry_cnt <= '0;
                    if (last_q) begin
`ifdef ABSORB_PAD_EN
                        st <= PAD;
`else
                        perm_req_q <= 1'b1;
                        st         <= PERM_WAIT;
`endif
                    end else begin
                        st <= ABSORB;
                    end
                end
`ifdef ABSORB_PAD_EN
                PAD: begin
                    state_o    <= merged_state;
                    padded_q   <= 1'b1;
                    perm_req_q <= 1'b1;
                    st         <= PERM_WAIT;
                end
`endif
                DONE: st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_absorb_stream.sv
// Randomised bench for absorb_stream against a byte-level sponge model.
// Builds with or without ABSORB_PAD_EN.
`timescale 1ns/1ps
module tb_absorb_stream;
    import keccak_pkg::*;

    localparam int DW = 256;
    localparam int BB = DW / 8;

    logic                   clk = 1'b0;
    logic                   rst_ni;
    logic                   start_i;
    logic [RATE_WIDTH-1:0]  rate_i;
    logic [7:0]             suffix_i;
    logic                   t_valid_i;
    logic                   t_ready_o;
    logic [DW-1:0]          t_data_i;
    logic [BB-1:0]          t_keep_i;
    logic                   t_last_i;
    logic [STATE_WIDTH-1:0] state_i;
    logic [STATE_WIDTH-1:0] state_o;
    logic                   perm_req_o;
    logic                   perm_done_i;
    logic                   absorb_done_o;

    always #5 clk = ~clk;

    absorb_stream #(.DWIDTH(DW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .rate_i        (rate_i),
        .suffix_i      (suffix_i),
        .t_valid_i     (t_valid_i),
        .t_ready_o     (t_ready_o),
        .t_data_i      (t_data_i),
        .t_keep_i      (t_keep_i),
        .t_last_i      (t_last_i),
        .state_i       (state_i),
        .state_o       (state_o),
        .perm_req_o    (perm_req_o),
        .perm_done_i   (perm_done_i),
        .absorb_done_o (absorb_done_o)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]    msg  [0:1023];
    logic [1599:0] blk  [0:15];
    logic [1599:0] snap [0:15];
    logic [1599:0] pstate;
    int            nblk;
    int            pidx;
    bit            resp_en;
    int            rates [0:4] = '{576, 832, 1088, 1152, 1344};

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int diff_byte(input logic [1599:0] a,
                                     input logic [1599:0] b);
        for (int i = 0; i < 200; i++)
            if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
        return -1;
    endfunction

    task automatic check_state(input string name, input logic [1599:0] act,
                               input logic [1599:0] exp);
        int d;
        tests++;
        d = diff_byte(act, exp);
        if (d >= 0) begin
            fails++;
            $display("FAIL %s: byte %0d got %02h want %02h",
                     name, d, act[d*8 +: 8], exp[d*8 +: 8]);
        end
    endtask

    function automatic logic [1599:0] rand_state();
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Sponge view: message split into rate-sized blocks, padded if enabled.
    task automatic build_model(input int len, input int rb,
                               input logic [7:0] suf);
        int total;
        logic [7:0] b;
`ifdef ABSORB_PAD_EN
        total = (len / rb + 1) * rb;
`else
        total = ((len + rb - 1) / rb) * rb;
        if (suf != SUFFIX_SHA3 && suf != SUFFIX_SHAKE)
            $display("note: unusual suffix %02h", suf);
`endif
        nblk = total / rb;
        for (int k = 0; k < 16; k++) blk[k] = '0;
        for (int i = 0; i < total; i++) begin
            b = (i < len) ? msg[i] : 8'h00;
`ifdef ABSORB_PAD_EN
            if (i == len) b = b ^ suf;
            if (i == total - 1) b = b ^ 8'h80;
`endif
            blk[i / rb][(i % rb) * 8 +: 8] = b;
        end
    endtask

    // Permutation stand-in: checks the absorbed block, returns random state.
    initial begin : responder
        logic [1599:0] nxt;
        forever begin
            @(negedge clk);
            if (resp_en && rst_ni && perm_req_o) begin
                if (pidx >= nblk) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_perm: perm %0d of %0d", pidx, nblk);
                end else begin
                    check_state("perm_block", state_o, pstate ^ blk[pidx]);
                end
                if (pidx < 16) snap[pidx] = state_o;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                nxt         = rand_state();
                state_i     = nxt;
                perm_done_i = 1'b1;
                pstate      = nxt;
                pidx++;
                @(negedge clk);
                perm_done_i = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (resp_en && rst_ni && perm_req_o)
                check("no_ready_in_perm", t_ready_o, 1'b0);
        end
    end

    task automatic start_msg(input int rate, input logic [7:0] suf);
        @(negedge clk);
        start_i  = 1'b1;
        rate_i   = RATE_WIDTH'(rate);
        suffix_i = suf;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_beat(input int pos, input int n, input bit last);
        int w;
        for (int b = 0; b < BB; b++) begin
            t_data_i[b*8 +: 8] = (b < n) ? msg[pos + b] : 8'($urandom);
            t_keep_i[b]        = (b < n);
        end
        t_last_i  = last;
        t_valid_i = 1'b1;
        w = 0;
        while (!t_ready_o && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: pos %0d", pos);
        end
        @(negedge clk);
        t_valid_i = 1'b0;
        t_last_i  = 1'b0;
        t_keep_i  = '0;
    endtask

    task automatic send_msg(input int len, input int chunk,
                            input bit do_last, input bit empty_last);
        int pos;
        int n;
        pos = 0;
        while (pos < len) begin
            n = (chunk > 0) ? chunk : $urandom_range(1, BB);
            if (n > len - pos) n = len - pos;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(pos, n, do_last && !empty_last && (pos + n == len));
            pos += n;
        end
        if (do_last && empty_last) send_beat(pos, 0, 1'b1);
    endtask

    task automatic run_msg(input int rate, input logic [7:0] suf,
                           input int len, input int chunk, input bit empty_last);
        int w;
        build_model(len, rate / 8, suf);
        pidx    = 0;
        pstate  = '0;
        resp_en = 1'b1;
        start_msg(rate, suf);
        check("ready_after_start", t_ready_o, 1'b1);
        send_msg(len, chunk, 1'b1, empty_last);
        w = 0;
        while (!absorb_done_o && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!absorb_done_o) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: len %0d rate %0d", len, rate);
        end else begin
            check("perm_count", 64'(pidx), 64'(nblk));
            check_state("done_state", state_o, pstate);
            @(negedge clk);
            check("done_pulse", absorb_done_o, 1'b0);
            check("idle_ready", t_ready_o, 1'b0);
        end
    endtask

    initial begin : main
        int w;
        int rate;
        int len;
        bit empty;
        logic [7:0] suf;

        rst_ni      = 1'b0;
        start_i     = 1'b0;
        rate_i      = '0;
        suffix_i    = '0;
        t_valid_i   = 1'b0;
        t_data_i    = '0;
        t_keep_i    = '0;
        t_last_i    = 1'b0;
        state_i     = '0;
        perm_done_i = 1'b0;
        resp_en     = 1'b0;
        pidx        = 0;
        nblk        = 0;
        pstate      = '0;
        repeat (3) @(negedge clk);
        check_state("rst_state", state_o, '0);
        check("rst_ready", t_ready_o, 1'b0);
        check("rst_perm_req", perm_req_o, 1'b0);
        check("rst_done", absorb_done_o, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk);

`ifdef ABSORB_PAD_EN
        for (int i = 0; i < 32; i++) msg[i] = 8'h11;
        run_msg(1088, SUFFIX_SHA3, 32, 32, 1'b0);
        for (int l = 0; l < 4; l++)
            check("short_lane", snap[0][l*64 +: 64], 64'h1111111111111111);
        check("short_suffix", snap[0][32*8 +: 8], 8'h06);
        check("short_pad_end", snap[0][135*8 +: 8], 8'h80);
        check("short_perms", 64'(pidx), 64'd1);

        for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom);
        run_msg(1344, SUFFIX_SHAKE, 167, 0, 1'b0);
        check("shake_pad_byte", snap[0][167*8 +: 8], 8'h9F);
        check("shake_perms", 64'(pidx), 64'd1);

        run_msg(576, SUFFIX_SHA3, 72, 24, 1'b0);
        check("sha512_exact_perms", 64'(pidx), 64'd2);

        run_msg(1088, SUFFIX_SHA3, 160, 32, 1'b1);
        check("carry_perms", 64'(pidx), 64'd2);
`else
        for (int i = 0; i < 136; i++) msg[i] = 8'h00;
        for (int i = 0; i < 32; i++) msg[i] = 8'h11;
        msg[32]  = 8'h06;
        msg[135] = 8'h80;
        run_msg(1088, SUFFIX_SHA3, 136, 32, 1'b0);
        check("prepad_perms", 64'(pidx), 64'd1);
        check("prepad_suffix", snap[0][32*8 +: 8], 8'h06);
        check("prepad_end", snap[0][135*8 +: 8], 8'h80);
        check("prepad_lane0", snap[0][63:0], 64'h1111111111111111);

        for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom);
        run_msg(576, SUFFIX_SHA3, 72, 24, 1'b0);
        check("exact_perms", 64'(pidx), 64'd1);

        run_msg(1088, SUFFIX_SHA3, 160, 32, 1'b1);
        check("carry_perms", 64'(pidx), 64'd2);
`endif

        // Restart mid-message: the second message must start from zero.
        for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom);
        start_msg(1088, SUFFIX_SHA3);
        send_msg(50, 25, 1'b0, 1'b0);
        run_msg(1088, SUFFIX_SHA3, 100, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom);
            rate  = rates[$urandom_range(0, 4)];
            suf   = ($urandom_range(0, 1) == 1) ? SUFFIX_SHAKE : SUFFIX_SHA3;
            len   = $urandom_range(1, 400);
            empty = ($urandom_range(0, 3) == 0);
`ifndef ABSORB_PAD_EN
            if (len % (rate / 8) == 0) empty = 1'b0;
`endif
            run_msg(rate, suf, len, 0, empty);
        end

        // Reset while a permutation is outstanding.
        resp_en = 1'b0;
        for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom);
        start_msg(1088, SUFFIX_SHA3);
        send_msg(136, 32, 1'b0, 1'b0);
        w = 0;
        while (!perm_req_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_pre_req", perm_req_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("rst_drop_req", perm_req_o, 1'b0);
        check_state("rst_clear_state", state_o, '0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        state_i     = rand_state();
        perm_done_i = 1'b1;
        @(negedge clk);
        perm_done_i = 1'b0;
        @(negedge clk);
        check("rst_ignore_req", perm_req_o, 1'b0);
        check_state("rst_ignore_state", state_o, '0);
        check("rst_ignore_ready", t_ready_o, 1'b0);
        check("rst_ignore_done", absorb_done_o, 1'b0);

        for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom);
        run_msg(1152, SUFFIX_SHA3, 200, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
